// File: rtl/reg_bank_ext_if.sv
// reg_bank_ext_if: bus bundle for the extended register bank.
// Carries everything except clock and reset:
//   load      write data
//   rsel      register enable mask, one bit per register
//   funsel    function applied to every selected register
//   clr_flags clears all sticky overflow flags
//   o1sel     read port 1 select
//   o2sel     read port 2 select
//   o1, o2    read port data
//   o1_zero   o1 == 0
//   o2_zero   o2 == 0
//   ovf       sticky overflow/underflow flag per register
// The master modport drives the bank; the slave modport is the bank itself.
interface reg_bank_ext_if #(
  parameter int WIDTH    = 8,
  parameter int NUM_REGS = 8,
  parameter int SEL_W    = $clog2(NUM_REGS)
);
  logic [WIDTH-1:0]    load;
  logic [NUM_REGS-1:0] rsel;
  logic [2:0]          funsel;
  logic                clr_flags;
  logic [SEL_W-1:0]    o1sel;
  logic [SEL_W-1:0]    o2sel;
  logic [WIDTH-1:0]    o1;
  logic [WIDTH-1:0]    o2;
  logic                o1_zero;
  logic                o2_zero;
  logic [NUM_REGS-1:0] ovf;

  modport master (
    output load, rsel, funsel, clr_flags, o1sel, o2sel,
    input  o1, o2, o1_zero, o2_zero, ovf
  );

  modport slave (
    input  load, rsel, funsel, clr_flags, o1sel, o2sel,
    output o1, o2, o1_zero, o2_zero, ovf
  );
endinterface

// File: rtl/reg_bank_ext.sv
// reg_bank_ext: parametrised general-purpose register bank.
// NUM_REGS registers of WIDTH bits. Every register whose rsel bit is set
// gets the same function each cycle (clear, load, dec, inc, hold, shl,
// shr, ror). Inc/dec either wrap or clamp (SATURATE), and any overflow
// or underflow raises a sticky per-register flag.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    reg_bank_ext_if slave modport (data, masks, selects, outputs)
// Two read ports; with REG_OUT=1 they are registered and capture the
// post-update value of the selected register so no stale data is shown.
module reg_bank_ext #(
  parameter int              WIDTH     = 8,
  parameter int              NUM_REGS  = 8,
  parameter int              SEL_W     = $clog2(NUM_REGS),
  parameter int              SATURATE  = 0,
  parameter int              REG_OUT   = 0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  reg_bank_ext_if.slave    bus
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  typedef enum logic [2:0] {
    FN_CLEAR = 3'b000,
    FN_LOAD  = 3'b001,
    FN_DEC   = 3'b010,
    FN_INC   = 3'b011,
    FN_HOLD  = 3'b100,
    FN_SHL   = 3'b101,
    FN_SHR   = 3'b110,
    FN_ROR   = 3'b111
  } fn_e;

  logic [WIDTH-1:0]    regs     [NUM_REGS];
  logic [WIDTH-1:0]    regs_nxt [NUM_REGS];
  logic [NUM_REGS-1:0] ovf_q;
  logic [NUM_REGS-1:0] ovf_set;
  logic [NUM_REGS-1:0] ovf_clr;
  logic [NUM_REGS-1:0] ovf_nxt;
  logic [WIDTH-1:0]    rd1;
  logic [WIDTH-1:0]    rd2;
  logic [WIDTH-1:0]    o1_out;
  logic [WIDTH-1:0]    o2_out;
  fn_e                 fn;

  assign fn = fn_e'(bus.funsel);

  // Next value and flag events for every register. Set and clear masks
  // are built separately so that a set always beats a clear on the same bit.
  always_comb begin
    ovf_set = '0;
    ovf_clr = {NUM_REGS{bus.clr_flags}};
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_nxt[i] = regs[i];
      if (bus.rsel[i]) begin
        case (fn)
          FN_CLEAR: begin
            regs_nxt[i] = '0;
            ovf_clr[i]  = 1'b1;
          end
          FN_LOAD: begin
            regs_nxt[i] = bus.load;
            ovf_clr[i]  = 1'b1;
          end
          FN_DEC: begin
            if (regs[i] == '0) begin
              regs_nxt[i] = (SATURATE != 0) ? '0 : ALL_ONES;
              ovf_set[i]  = 1'b1;
            end else begin
              regs_nxt[i] = regs[i] - 1'b1;
            end
          end
          FN_INC: begin
            if (regs[i] == ALL_ONES) begin
              regs_nxt[i] = (SATURATE != 0) ? ALL_ONES : '0;
              ovf_set[i]  = 1'b1;
            end else begin
              regs_nxt[i] = regs[i] + 1'b1;
            end
          end
          FN_SHL: begin
            regs_nxt[i] = {regs[i][WIDTH-2:0], 1'b0};
            ovf_set[i]  = regs[i][WIDTH-1];
          end
          FN_SHR: regs_nxt[i] = {1'b0, regs[i][WIDTH-1:1]};
          FN_ROR: regs_nxt[i] = {regs[i][0], regs[i][WIDTH-1:1]};
          default: regs_nxt[i] = regs[i];
        endcase
      end
    end
  end

  assign ovf_nxt = (ovf_q & ~ovf_clr) | ovf_set;

  // Register array and sticky flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= RESET_VAL;
      end
      ovf_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= regs_nxt[i];
      end
      ovf_q <= ovf_nxt;
    end
  end

  // Read muxes. Registered ports sample the post-update values so a
  // register written on this edge is forwarded; combinational ports read
  // current state. Selects with no matching register read as zero.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (bus.o1sel == SEL_W'(i)) begin
        rd1 = (REG_OUT != 0) ? regs_nxt[i] : regs[i];
      end
      if (bus.o2sel == SEL_W'(i)) begin
        rd2 = (REG_OUT != 0) ? regs_nxt[i] : regs[i];
      end
    end
  end

  generate
    if (REG_OUT != 0) begin : g_reg_out
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          o1_out <= '0;
          o2_out <= '0;
        end else begin
          o1_out <= rd1;
          o2_out <= rd2;
        end
      end
    end else begin : g_comb_out
      assign o1_out = rd1;
      assign o2_out = rd2;
    end
  endgenerate

  assign bus.o1      = o1_out;
  assign bus.o2      = o2_out;
  assign bus.o1_zero = (o1_out == '0);
  assign bus.o2_zero = (o2_out == '0);
  assign bus.ovf     = ovf_q;

endmodule

// File: doc/reg_bank_ext.md
Name: reg_bank_ext

Overview:
- Parametrised successor of the 8-bit general-purpose register file.
- Holds NUM_REGS registers of WIDTH bits; a one-hot/multi-hot select mask applies one function to any subset of them each cycle.
- Two independent read ports, with optional registered outputs and write-forwarding.
- Adds saturating or wrapping increment/decrement, shifts, and sticky per-register overflow flags.
- Feeds the MuxC/ALU datapath in the ALU system, replacing the fixed R/T bank.

Parameters:
WIDTH, 8, data width of each register (>=2)
NUM_REGS, 8, number of registers (2..16)
SEL_W, $clog2(NUM_REGS), read-select width (derived)
SATURATE, 0, 0 = inc/dec wrap, 1 = inc/dec clamp at all-ones/zero
REG_OUT, 0, 0 = combinational read ports, 1 = registered read ports with forwarding
RESET_VAL, 0, reset value of every register

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
load  in  WIDTH  write data
rsel  in  NUM_REGS  register enable mask, bit i = register i, multi-hot allowed
funsel  in  3  function applied to every selected register
clr_flags  in  1  clears all sticky overflow flags
o1sel  in  SEL_W  read port 1 select
o2sel  in  SEL_W  read port 2 select
o1  out  WIDTH  read port 1 data
o2  out  WIDTH  read port 2 data
o1_zero  out  1  o1 == 0
o2_zero  out  1  o2 == 0
ovf  out  NUM_REGS  sticky overflow/underflow flag per register

Behaviour:
- Reset (rst_n low, asynchronous):
  - all registers = RESET_VAL, ovf = 0.
  - When REG_OUT=1, o1 and o2 = 0.
  - Holds while rst_n is low. First update happens on the first rising edge after deassertion.
- funsel encodings, applied on the rising edge to each register i with rsel[i]=1:
  - 000 clear to 0
  - 001 load
  - 010 decrement
  - 011 increment
  - 100 hold
  - 101 logical shift left by 1
  - 110 logical shift right by 1
  - 111 rotate right by 1
- Unselected registers hold. rsel=0 means no register changes.
- Increment at all-ones:
  - SATURATE=0: wraps to 0 and sets ovf[i].
  - SATURATE=1: stays at all-ones and sets ovf[i].
- Decrement at 0:
  - SATURATE=0: wraps to all-ones and sets ovf[i].
  - SATURATE=1: stays at 0 and sets ovf[i].
- Shift left with MSB=1 sets ovf[i]. Shift right and rotate never set ovf.
- ovf clearing:
  - ovf[i] clears on clear (000) or load (001) of register i.
  - clr_flags clears all bits on the edge.
  - If a set event and a clear (clr_flags, or clear/load) coincide for the same bit in one cycle, set wins. This cannot happen for clear/load itself, since clear/load never overflows.
- Read path:
  - o1/o2 = register[o1sel]/register[o2sel].
  - A select >= NUM_REGS reads as 0.
  - Both ports may select the same register.
- REG_OUT=0:
  - Reads are combinational from current state.
  - A write becomes visible immediately after the edge; zero-latency read-after-write is not provided.
- REG_OUT=1:
  - o1/o2 are registered, 1-cycle latency.
  - The value captured at edge k is the post-update value of the selected register at edge k (write-forwarded). The outputs therefore never show stale data for a register written in the same cycle.
- o1_zero/o2_zero are combinational from o1/o2 in both modes.
- All arithmetic is modulo 2^WIDTH, with no carry outputs other than ovf.

Test Plan:
- Reset: rst_n low mid-cycle with registers nonzero -> immediately all registers 0, ovf=0, o1=o2=0, o1_zero=1.
- Multi-hot load: rsel=8'b0000_0101, funsel=001, load=8'hA5, then o1sel=0, o2sel=2 -> o1=o2=8'hA5; register 1 is unchanged at 0.
- Wrap vs saturate:
  - reg3=8'hFF, funsel=011: SATURATE=0 -> reg3=8'h00, ovf[3]=1; SATURATE=1 -> reg3=8'hFF, ovf[3]=1.
  - reg3=8'h00, funsel=010 with SATURATE=1 -> 8'h00, ovf[3]=1.
- Sticky flag priority: ovf[3]=1, assert clr_flags in the same cycle that reg3 increments from 8'hFF -> ovf[3] remains 1. The next cycle with clr_flags only -> ovf[3]=0.
- Registered forwarding (REG_OUT=1): o1sel=4, load reg4=8'h3C at edge k -> o1=8'h3C right after edge k. Increment at edge k+1 -> o1=8'h3D after k+1.
- Shift/rotate and out-of-range read:
  - reg5=8'h81: funsel=101 -> 8'h02, ovf[5]=1; funsel=111 on 8'h81 -> 8'hC0.
  - NUM_REGS=6, o2sel=7 -> o2=0, o2_zero=1.
